// File: rtl/flash_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : flash_fetch_unit
// Purpose  : Fetches 32-bit instructions from SPI NOR flash (READ 0x03) and
//            keeps a one-entry last-address buffer for repeated PCs.
// Revision : 1.0 - initial release
// ============================================================================
module flash_fetch_unit #(
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic        flashClk,
    input  logic        flashMiso,
    output logic        flashMosi,
    output logic        flashCs
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [31:0]        c_NOP      = 32'h0000_0013;
    localparam logic [7:0]         c_CMD_READ = 8'h03;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CS_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT    = 3'd2;
    localparam logic [2:0] c_CS_HOLD  = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;
    localparam logic [2:0] c_DESELECT = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_DIV_W-1:0] r_div;
    logic               r_phase;
    logic [6:0]         r_bit;
    logic [31:0]        r_tx;
    logic [31:0]        r_rx;
    logic [31:0]        r_addr;
    logic [31:0]        r_tag;
    logic               r_tag_valid;
    logic               r_miss;
    logic               r_ready;
    logic               r_valid;
    logic [31:0]        r_instr;
    logic               r_sck;
    logic               r_mosi;
    logic               r_cs;

    logic [31:0] w_req_addr;
    logic [23:0] w_flash_addr;
    logic        w_accept;
    logic        w_hit;
    logic        w_div_end;
    logic        w_bit_end;
    logic        w_sample;
    logic        w_complete;

    assign w_req_addr   = fetch_addr & 32'hFFFF_FFFC;
    assign w_flash_addr = FLASH_BASE + w_req_addr[23:0];
    assign w_accept     = (r_state == c_IDLE) && fetch_req;
    assign w_hit        = r_tag_valid && (r_tag == w_req_addr);
    assign w_div_end    = (r_div == c_DIV_LAST);
    assign w_bit_end    = (r_state == c_SHIFT) && r_phase && w_div_end;
    // First cycle of the high half-period: the edge that raises the pin SCK.
    assign w_sample     = (r_state == c_SHIFT) && r_phase && (r_div == '0) && r_bit[5];
    assign w_complete   = (r_state == c_DONE) && r_miss;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (fetch_req) w_next_state = w_hit ? c_DONE : c_CS_SETUP;
            c_CS_SETUP: if (w_div_end) w_next_state = c_SHIFT;
            c_SHIFT:    if (w_bit_end && (r_bit == 7'd63)) w_next_state = c_CS_HOLD;
            c_CS_HOLD:  if (w_div_end) w_next_state = c_DONE;
            c_DONE:     w_next_state = r_miss ? c_DESELECT : c_IDLE;
            c_DESELECT: if (w_div_end) w_next_state = c_IDLE;
            default:    w_next_state = c_IDLE;
        endcase
    end

    // Pin registers follow the sequencer state one cycle later, so the pin view
    // of every phase keeps its full length and the pins are glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_div       <= '0;
            r_phase     <= 1'b0;
            r_bit       <= 7'd0;
            r_tx        <= 32'd0;
            r_rx        <= 32'd0;
            r_addr      <= 32'd0;
            r_tag       <= 32'd0;
            r_tag_valid <= 1'b0;
            r_miss      <= 1'b0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_instr     <= c_NOP;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs        <= 1'b1;
        end else begin
            r_state <= w_next_state;

            if ((r_state == c_IDLE) || (r_state == c_DONE) || (w_next_state != r_state) || w_div_end)
                r_div <= '0;
            else
                r_div <= r_div + c_DIV_W'(1);

            if (r_state != c_SHIFT)
                r_phase <= 1'b0;
            else if (w_div_end)
                r_phase <= ~r_phase;

            if (r_state != c_SHIFT)
                r_bit <= 7'd0;
            else if (w_bit_end)
                r_bit <= r_bit + 7'd1;

            if (w_accept) begin
                r_addr <= w_req_addr;
                r_miss <= !w_hit;
                r_tx   <= {c_CMD_READ, w_flash_addr};
            end else if (w_bit_end) begin
                r_tx <= {r_tx[30:0], 1'b0};
            end

            if (w_sample)
                r_rx <= {r_rx[30:0], flashMiso};

            if (w_complete) begin
                r_instr     <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                r_tag       <= r_addr;
                r_tag_valid <= 1'b1;
            end

            r_valid <= (w_accept && w_hit) || w_complete;
            r_ready <= (w_next_state == c_IDLE);
            r_cs    <= !((r_state == c_CS_SETUP) || (r_state == c_SHIFT) || (r_state == c_CS_HOLD));
            r_sck   <= (r_state == c_SHIFT) && r_phase;
            r_mosi  <= ((r_state == c_CS_SETUP) || (r_state == c_SHIFT)) && r_tx[31];
        end
    end

    assign fetch_ready       = r_ready;
    assign instruction_valid = r_valid;
    assign instruction       = r_instr;
    assign flashClk          = r_sck;
    assign flashMosi         = r_mosi;
    assign flashCs           = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_flash_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_fetch_unit
// Purpose  : Directed self-checking bench with a behavioural SPI flash per DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_req = 1'b0;
    logic [31:0] a_addr = 32'd0;
    logic        a_ready, a_valid, a_sck, a_mosi, a_cs;
    logic [31:0] a_instr;
    logic        a_miso = 1'b0;

    logic        b_req = 1'b0;
    logic [31:0] b_addr = 32'd0;
    logic        b_ready, b_valid, b_sck, b_mosi, b_cs;
    logic [31:0] b_instr;
    logic        b_miso = 1'b0;

    int passed = 0;
    int total  = 0;

    logic [7:0] flash_mem [0:255];

    always #5 clock = ~clock;

    flash_fetch_unit #(.CLK_DIV(2), .FLASH_BASE(24'h000000)) dut_a (
        .clock(clock), .reset(reset), .fetch_req(a_req), .fetch_addr(a_addr),
        .fetch_ready(a_ready), .instruction_valid(a_valid), .instruction(a_instr),
        .flashClk(a_sck), .flashMiso(a_miso), .flashMosi(a_mosi), .flashCs(a_cs)
    );

    flash_fetch_unit #(.CLK_DIV(1), .FLASH_BASE(24'hFFFFFC)) dut_b (
        .clock(clock), .reset(reset), .fetch_req(b_req), .fetch_addr(b_addr),
        .fetch_ready(b_ready), .instruction_valid(b_valid), .instruction(b_instr),
        .flashClk(b_sck), .flashMiso(b_miso), .flashMosi(b_mosi), .flashCs(b_cs)
    );

    function automatic logic flash_bit(input logic [23:0] base, input int idx);
        logic [7:0] a8;
        logic [7:0] byte_v;
        a8     = base[7:0] + 8'(idx / 8);
        byte_v = flash_mem[a8];
        return byte_v[7 - (idx % 8)];
    endfunction

    // Flash model A: captures command+address on SCK rise, drives data on SCK fall.
    int          a_bits = 0, a_rises_low = 0, a_rises_high = 0, a_cs_low = 0;
    logic [31:0] a_rx = 32'd0;
    always @(negedge a_cs) a_bits = 0;
    always @(posedge a_sck) begin
        if (a_cs) a_rises_high++;
        else begin
            if (a_bits < 32) a_rx = {a_rx[30:0], a_mosi};
            a_bits++;
            a_rises_low++;
        end
    end
    always @(negedge a_sck)
        if (!a_cs && a_bits >= 32 && a_bits < 64) a_miso = flash_bit(a_rx[23:0], a_bits - 32);
    always @(posedge clock) if (!a_cs) a_cs_low++;

    int          b_bits = 0, b_rises_low = 0;
    logic [31:0] b_rx = 32'd0;
    always @(negedge b_cs) b_bits = 0;
    always @(posedge b_sck) begin
        if (!b_cs) begin
            if (b_bits < 32) b_rx = {b_rx[30:0], b_mosi};
            b_bits++;
            b_rises_low++;
        end
    end
    always @(negedge b_sck)
        if (!b_cs && b_bits >= 32 && b_bits < 64) b_miso = flash_bit(b_rx[23:0], b_bits - 32);

    // Issues one request on A and returns edges from accept to the valid pulse.
    task automatic fetch_a(input logic [31:0] addr, output int lat);
        lat = -1;
        for (int i = 0; i < 400 && !a_ready; i++) @(negedge clock);
        a_addr = addr;
        a_req  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_req  = 1'b0;
        a_addr = 32'hDEAD_BEEF;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (a_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic fetch_b(input logic [31:0] addr, output int lat);
        lat = -1;
        for (int i = 0; i < 400 && !b_ready; i++) @(negedge clock);
        b_addr = addr;
        b_req  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        b_req  = 1'b0;
        b_addr = 32'hDEAD_BEEF;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (b_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r0, c0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", a_ready); else passed++;
        total++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_valid); else passed++;
        total++; if (a_instr !== 32'h00000013) $display("FAIL reset_instr: got %h expected 00000013", a_instr); else passed++;
        total++; if (a_cs !== 1'b1 || a_sck !== 1'b0 || a_mosi !== 1'b0)
                     $display("FAIL reset_pins: got cs=%b sck=%b mosi=%b expected 1 0 0", a_cs, a_sck, a_mosi); else passed++;
        reset = 1'b0;
        r0 = a_rises_low + a_rises_high;
        c0 = a_cs_low;
        repeat (100) @(negedge clock);
        total++; if (a_rises_low + a_rises_high - r0 !== 0)
                     $display("FAIL idle_sck: got %0d edges expected 0", a_rises_low + a_rises_high - r0); else passed++;
        total++; if (a_cs_low - c0 !== 0 || a_ready !== 1'b1)
                     $display("FAIL idle_cs: got cs_low=%0d ready=%b expected 0 1", a_cs_low - c0, a_ready); else passed++;
    endtask

    task automatic test_miss();
        int lat, r0, c0;
        r0 = a_rises_low;
        c0 = a_cs_low;
        fetch_a(32'h0000_0004, lat);
        total++; if (lat !== 261) $display("FAIL miss_latency: got %0d expected 261", lat); else passed++;
        total++; if (a_instr !== 32'h00100093) $display("FAIL miss_instr: got %h expected 00100093", a_instr); else passed++;
        total++; if (a_rx !== 32'h03000004) $display("FAIL miss_mosi: got %h expected 03000004", a_rx); else passed++;
        total++; if (a_rises_low - r0 !== 64) $display("FAIL miss_sck_count: got %0d expected 64", a_rises_low - r0); else passed++;
        total++; if (a_cs_low - c0 !== 260) $display("FAIL miss_cs_low: got %0d expected 260", a_cs_low - c0); else passed++;
        total++; if (a_cs !== 1'b1 || a_ready !== 1'b0)
                     $display("FAIL miss_deselect: got cs=%b ready=%b expected 1 0", a_cs, a_ready); else passed++;
        @(negedge clock);
        total++; if (a_valid !== 1'b0) $display("FAIL miss_pulse: got %b expected 0", a_valid); else passed++;
        total++; if (a_rises_high !== 0) $display("FAIL sck_cs_high: got %0d expected 0", a_rises_high); else passed++;
    endtask

    task automatic test_hit();
        int r0, c0;
        logic [3:0] v;
        for (int i = 0; i < 400 && !a_ready; i++) @(negedge clock);
        r0 = a_rises_low;
        c0 = a_cs_low;
        a_addr = 32'h0000_0005;
        a_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            v[k] = a_valid;
            if (k == 0) begin
                total++; if (a_instr !== 32'h00100093) $display("FAIL hit_instr: got %h expected 00100093", a_instr); else passed++;
            end
            if (k == 1) begin
                total++; if (a_ready !== 1'b1) $display("FAIL hit_ready: got %b expected 1", a_ready); else passed++;
            end
        end
        a_req = 1'b0;
        total++; if (v !== 4'b0101) $display("FAIL hit_valid_seq: got %b expected 0101", v); else passed++;
        total++; if (a_cs_low - c0 !== 0 || a_rises_low - r0 !== 0)
                     $display("FAIL hit_no_flash: got cs_low=%0d sck=%0d expected 0 0", a_cs_low - c0, a_rises_low - r0); else passed++;
    endtask

    task automatic test_addr_align();
        int lat;
        fetch_a(32'h0000_000B, lat);
        total++; if (lat !== 261) $display("FAIL align_latency: got %0d expected 261", lat); else passed++;
        total++; if (a_rx !== 32'h03000008) $display("FAIL align_addr: got %h expected 03000008", a_rx); else passed++;
        total++; if (a_instr !== 32'h02A00513) $display("FAIL align_instr: got %h expected 02a00513", a_instr); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, c0;
        for (int i = 0; i < 400 && !a_ready; i++) @(negedge clock);
        a_addr = 32'h0000_0004;
        a_req  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_req = 1'b0;
        for (int i = 0; i < 400 && a_bits != 40; i++) @(negedge clock);
        total++; if (a_bits !== 40) $display("FAIL midreset_reach: got %0d bits expected 40", a_bits); else passed++;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        total++; if (a_cs !== 1'b1 || a_sck !== 1'b0)
                     $display("FAIL midreset_pins: got cs=%b sck=%b expected 1 0", a_cs, a_sck); else passed++;
        total++; if (a_instr !== 32'h00000013 || a_valid !== 1'b0)
                     $display("FAIL midreset_instr: got %h valid=%b expected 00000013 0", a_instr, a_valid); else passed++;
        reset = 1'b0;
        @(negedge clock);
        c0 = a_cs_low;
        fetch_a(32'h0000_000B, lat);
        total++; if (lat !== 261) $display("FAIL midreset_refetch: got %0d expected 261", lat); else passed++;
        total++; if (a_cs_low - c0 !== 260) $display("FAIL midreset_cs: got %0d expected 260", a_cs_low - c0); else passed++;
        total++; if (a_instr !== 32'h02A00513) $display("FAIL midreset_instr2: got %h expected 02a00513", a_instr); else passed++;
    endtask

    task automatic test_wrap();
        int lat, r0;
        r0 = b_rises_low;
        fetch_b(32'h0000_0008, lat);
        total++; if (lat !== 131) $display("FAIL wrap_latency: got %0d expected 131", lat); else passed++;
        total++; if (b_rx !== 32'h03000004) $display("FAIL wrap_addr: got %h expected 03000004", b_rx); else passed++;
        total++; if (b_instr !== 32'h00100093) $display("FAIL wrap_instr: got %h expected 00100093", b_instr); else passed++;
        total++; if (b_rises_low - r0 !== 64) $display("FAIL wrap_sck_count: got %0d expected 64", b_rises_low - r0); else passed++;
    endtask

    task automatic test_back_to_back();
        int   accepts, valids, consec, falls, high_run, min_high, viol, extra;
        logic prev_valid, prev_cs, seen_low;
        for (int i = 0; i < 400 && !b_ready; i++) @(negedge clock);
        accepts = 0; valids = 0; consec = 0; falls = 0; high_run = 0; min_high = 1000;
        viol = 0; extra = 0; prev_valid = 1'b0; prev_cs = b_cs; seen_low = 1'b0;
        b_addr = 32'h0000_0010;
        b_req  = 1'b1;
        for (int n = 0; n < 1000 && b_req; n++) begin
            if (b_ready) accepts++;
            @(posedge clock);
            @(negedge clock);
            if (b_valid) begin
                valids++;
                if (prev_valid) consec++;
                if (valids == 1) b_addr = 32'h0000_0014;
                else if (valids == 2) b_addr = 32'h0000_0018;
                else b_req = 1'b0;
            end
            prev_valid = b_valid;
            if (!b_cs && b_ready) viol++;
            if (b_cs) high_run++;
            else begin
                if (prev_cs) begin
                    falls++;
                    if (seen_low && high_run < min_high) min_high = high_run;
                    seen_low = 1'b1;
                end
                high_run = 0;
            end
            prev_cs = b_cs;
        end
        b_req = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (b_valid) extra++;
        end
        total++; if (valids !== 3 || extra !== 0) $display("FAIL b2b_valids: got %0d+%0d expected 3+0", valids, extra); else passed++;
        total++; if (consec !== 0) $display("FAIL b2b_pulse_width: got %0d long pulses expected 0", consec); else passed++;
        total++; if (accepts !== 3 || falls !== 3) $display("FAIL b2b_transactions: got acc=%0d cs_falls=%0d expected 3 3", accepts, falls); else passed++;
        total++; if (min_high < 1) $display("FAIL b2b_cs_high: got %0d expected >=1", min_high); else passed++;
        total++; if (viol !== 0) $display("FAIL b2b_ready_busy: got %0d expected 0", viol); else passed++;
        total++; if (b_instr !== 32'hA29B948D) $display("FAIL b2b_instr: got %h expected a29b948d", b_instr); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) flash_mem[i] = 8'(i * 7 + 1);
        flash_mem[4]  = 8'h93; flash_mem[5]  = 8'h00; flash_mem[6]  = 8'h10; flash_mem[7]  = 8'h00;
        flash_mem[8]  = 8'h13; flash_mem[9]  = 8'h05; flash_mem[10] = 8'hA0; flash_mem[11] = 8'h02;
        test_reset();
        test_miss();
        test_hit();
        test_addr_align();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_fetch_unit.md
# flash_fetch_unit

Instruction-fetch stage that reads 32-bit RISC-V instructions directly from the board's external SPI NOR flash and hands them to the IF/ID pipeline registers. It sits between the PC register and `if_id_pipeline_registers`, replacing the on-chip ROM as the instruction source. On each accepted fetch request it issues a standard READ (0x03) transaction and returns the little-endian word. A one-entry last-address buffer lets repeated fetches of the same PC complete without a flash transaction.

## Interface
- `CLK_DIV`, 2: flashClk half-period in `clock` cycles; legal values ≥1.
- `FLASH_BASE`, 24'h000000: flash byte offset added to every fetch address.
- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: request a fetch of `fetch_addr`.
- `fetch_addr` in 32: byte PC; bits [1:0] are ignored and treated as 0.
- `fetch_ready` out 1: unit idle and able to accept `fetch_req` this cycle.
- `instruction_valid` out 1: one-cycle pulse; `instruction` is new this cycle.
- `instruction` out 32: last fetched instruction, held until the next completion.
- `flashClk` out 1: SPI SCK, mode 0 (idle low).
- `flashMiso` in 1: SPI data from flash.
- `flashMosi` out 1: SPI data to flash.
- `flashCs` out 1: SPI chip select, active low.

## Operation
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE, DESELECT.
- IDLE: `fetch_ready`=1. A request is accepted on an edge with `fetch_req`=1 and `fetch_ready`=1. The accepted address is latched as `{fetch_addr[31:2],2'b00}`.
  - Hit: the latched address equals the hit tag and the tag is valid. Go to DONE; `instruction` is unchanged.
  - Miss: go to CS_SETUP.
- Flash byte address = (FLASH_BASE + fetch_addr[23:0] with [1:0]=0) mod 2^24. Carries wrap silently.
- CS_SETUP, CLK_DIV cycles: `flashCs`=0, `flashClk`=0, `flashMosi` = command bit 7.
- SHIFT: 64 bit periods, 7-bit counter 0..63. Each period has `flashClk`=0 for CLK_DIV cycles, then `flashClk`=1 for CLK_DIV cycles.
  - Bits 0–7 carry command 0x03; bits 8–31 carry the address, MSB first. `flashMosi` changes only while `flashClk` is low.
  - Bits 32–63 are data. `flashMiso` is sampled on the edge that drives `flashClk` 0→1. `flashMosi`=0 during data bits.
- Assembly: flash byte k (k=0..3) is received MSB first and lands in `instruction[8k+7:8k]`.
- CS_HOLD, CLK_DIV cycles: `flashClk`=0, `flashCs`=0. On exit, `flashCs`=1 and `instruction` is loaded with the assembled word. The hit tag is set to the latched address and marked valid.
- DONE, 1 cycle: `instruction_valid`=1. Next state is DESELECT on the miss path, IDLE on the hit path.
- DESELECT, CLK_DIV cycles: `flashCs`=1, `fetch_ready`=0. This enforces the minimum CS-high time. Then go to IDLE.
- `fetch_req` is ignored whenever `fetch_ready`=0. `fetch_addr` need not be held after acceptance.

## Timing
- Reset values: state IDLE, `fetch_ready`=1, `instruction_valid`=0, `instruction`=32'h00000013 (NOP), `flashCs`=1, `flashClk`=0, `flashMosi`=0, hit tag invalid.
- Reset mid-transaction: on the next edge `flashCs`=1 and `flashClk`=0. The partial word is discarded and `instruction` becomes the NOP.
- Miss latency: `instruction_valid` is high in the cycle following the edge 130·CLK_DIV+1 edges after the accepting edge. For CLK_DIV=2 that is edge 261.
- Miss throughput: the next accept is possible CLK_DIV cycles after the valid cycle.
- Hit latency: `instruction_valid` is high in the cycle immediately after the accepting edge. Back-to-back hits complete every 2 cycles.
- Outputs are registered; no combinational path from `flashMiso` or `fetch_req` to any output.
- `flashClk` frequency = f(clock)/(2·CLK_DIV). No glitches on `flashCs` or `flashClk`.

## Test plan
- Reset release, no request -> `fetch_ready`=1, `instruction`=32'h00000013, `flashCs`=1, `flashClk`=0, no SCK edges for 100 cycles.
- Fetch 0x00000004, FLASH_BASE=0, flash model bytes at 4..7 = 93 00 10 00 -> MOSI stream 0x03,0x000004. Valid 261 edges after accept (CLK_DIV=2). `instruction`=32'h00100093. Exactly 64 SCK rising edges with `flashCs` low.
- Same address requested again -> valid on the next cycle, no `flashCs` activity, `instruction` unchanged.
- FLASH_BASE=24'hFFFFFC, fetch 0x00000008 -> address sent 0x000004 (wrap). `fetch_addr`=0x0000000B -> address 0x000008 for FLASH_BASE=0.
- `reset` asserted at data bit 40 -> `flashCs`=1 next edge. `instruction`=NOP. The following fetch of the same address goes to flash, because the tag was invalidated.
- `fetch_req` held high continuously with CLK_DIV=1 -> requests are accepted only while `fetch_ready`=1, `flashCs` high ≥1 cycle between transactions, valid pulses one cycle each.
